// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (IDLE/ARMED/HIT Moore FSM).
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               j,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               arm,
  input  logic               disarm,
  output logic               w,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  state_t             state_q, state_d;
  // The oldest bit falls out of any comparison once the new bit arrives,
  // so only MAX_LEN-1 past bits are kept; j completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_ok;
  logic               match;
  logic               arm_go;

  assign window   = {hist_q, j};
  assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
  assign cfg_ok   = (state_q == IDLE) && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    match   = 1'b0;
    arm_go  = 1'b0;

    if (cfg_we) begin
      if (cfg_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!disarm && arm) begin
          state_d = ARMED;
          hist_d  = '0;
          fill_d  = '0;
          arm_go  = 1'b1;
        end
      end
      ARMED, HIT: begin
        if (disarm) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED;
          if (in_valid) begin
            hist_d = window[MAX_LEN-2:0];
            fill_d = fill_inc;
            if ((fill_inc >= len_q) && (((window ^ pat_q) & mask) == '0)) begin
              match   = 1'b1;
              state_d = HIT;
              if (!ovl_q) begin
                fill_d = '0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= LEN_W'(MAX_LEN);
      ovl_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
    end
  end

  assign w       = (state_q == HIT);
  assign armed   = (state_q != IDLE);
  assign cfg_err = err_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arm_go) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_unused;
  assign cnt_unused = match ^ arm_go;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomized and directed bench for seq_detect_prog, checked every cycle against a queue-based model.
module tb_seq_detect_prog;
  localparam int ML = 8;
  localparam int LW = 4;
  localparam int CW = 2;
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          j, in_valid, cfg_we, cfg_overlap, arm, disarm;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          w, armed, cfg_err;
  logic [CW-1:0] match_cnt;

  int tests = 0;
  int fails = 0;

  seq_detect_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .j(j), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .arm(arm), .disarm(disarm), .w(w), .armed(armed), .cfg_err(cfg_err),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the last clear, newest at the back.
  bit            m_q[$];
  logic [ML-1:0] m_pat = '0;
  int            m_len = ML;
  bit            m_ovl = 1'b1;
  bit            m_armed = 1'b0;
  bit            m_w = 1'b0;
  bit            m_err = 1'b0;
  int            m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
    int lim = (1 << CW) - 1;
    if (!CNT_ON) return 0;
    return (n > lim) ? lim : n;
  endfunction

  always begin
    bit hit;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_pat = '0; m_len = ML; m_ovl = 1'b1;
      m_armed = 1'b0; m_w = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (cfg_we) begin
        if (!m_armed && cfg_len >= 1 && int'(cfg_len) <= ML) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      m_w = 1'b0;
      if (disarm) begin
        m_armed = 1'b0;
      end else if (!m_armed) begin
        if (arm) begin
          m_armed = 1'b1;
          m_q.delete();
          m_cnt = 0;
        end
      end else if (in_valid) begin
        m_q.push_back(j);
        if (m_q.size() > ML) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          if (hit) begin
            m_w = 1'b1;
            m_cnt++;
            if (!m_ovl) m_q.delete();
          end
        end
      end
    end
    #1;
    chk("w", 32'(w), 32'(m_w));
    chk("armed", 32'(armed), 32'(m_armed));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("match_cnt", 32'(match_cnt), 32'(cnt_exp(m_cnt)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    j = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; arm = 1'b0; disarm = 1'b0;
  endtask

  task automatic setup(input logic [ML-1:0] p, input int l, input logic o);
    clr_in(); disarm = 1'b1; tick();
    clr_in(); cfg_we = 1'b1; cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; arm = 1'b1;
    tick(); clr_in();
  endtask

  task automatic send(input logic [31:0] bits, input int n, output logic [31:0] wv);
    wv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      j = bits[i]; in_valid = 1'b1;
      tick();
      wv = {wv[30:0], w};
    end
    clr_in();
  endtask

  initial begin
    logic [31:0] wv, idle_w;
    rst = 1'b1; clr_in(); cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_w", 32'(w), 0);
    chk("reset_armed", 32'(armed), 0);
    chk("reset_cfg_err", 32'(cfg_err), 0);
    chk("reset_cnt", 32'(match_cnt), 0);

    // 10110 overlapping / non-overlapping
    setup(8'b10110, 5, 1'b1);
    chk("armed_after_arm", 32'(armed), 1);
    send(32'b10110110, 8, wv);
    chk("ovl1_w_seq", wv, 32'b00001001);
    chk("ovl1_cnt", 32'(match_cnt), 32'(cnt_exp(2)));
    setup(8'b10110, 5, 1'b0);
    send(32'b10110110, 8, wv);
    chk("ovl0_w_seq", wv, 32'b00001000);
    chk("ovl0_cnt", 32'(match_cnt), 32'(cnt_exp(1)));

    // 11 over 1111
    setup(8'b11, 2, 1'b1);
    send(32'b1111, 4, wv);
    chk("p11_ovl1", wv, 32'b0111);
    setup(8'b11, 2, 1'b0);
    send(32'b1111, 4, wv);
    chk("p11_ovl0", wv, 32'b0101);

    // gap of three invalid cycles inside a match
    setup(8'b10110, 5, 1'b1);
    send(32'b101, 3, wv);
    chk("gap_head", wv, 0);
    idle_w = '0;
    for (int i = 0; i < 3; i++) begin tick(); idle_w = {idle_w[30:0], w}; end
    chk("gap_idle", idle_w, 0);
    send(32'b10, 2, wv);
    chk("gap_tail", wv, 32'b01);
    tick();
    chk("gap_pulse_end", 32'(w), 0);

    // rejected configuration writes
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd5; cfg_overlap = 1'b1;
    tick(); clr_in();
    chk("err_while_armed", 32'(cfg_err), 1);
    disarm = 1'b1; tick(); clr_in();
    arm = 1'b1; tick(); clr_in();
    send(32'b10110, 5, wv);
    chk("pattern_kept", wv, 32'b00001);
    disarm = 1'b1; tick(); clr_in();
    cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd0; tick(); clr_in();
    chk("err_len0", 32'(cfg_err), 1);
    cfg_we = 1'b1; cfg_len = 4'd9; tick(); clr_in();
    chk("err_len9", 32'(cfg_err), 1);
    cfg_we = 1'b1; cfg_pattern = 8'b10110; cfg_len = 4'd5; tick(); clr_in();
    chk("err_cleared", 32'(cfg_err), 0);

    // length 1 and counter saturation
    setup(8'h01, 1, 1'b0);
    send(32'b11111, 5, wv);
    chk("len1_w_seq", wv, 32'b11111);
    chk("cnt_sat", 32'(match_cnt), 32'(cnt_exp(5)));
    send(32'b101, 3, wv);
    chk("len1_mixed", wv, 32'b101);

    // reset mid-stream
    setup(8'b10110, 5, 1'b1);
    send(32'b1011, 4, wv);
    chk("pre_rst_w", wv, 0);
    cfg_we = 1'b1; cfg_len = 4'd5; tick(); clr_in();
    chk("pre_rst_err", 32'(cfg_err), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_w", 32'(w), 0);
    chk("rst_async_armed", 32'(armed), 0);
    chk("rst_async_err", 32'(cfg_err), 0);
    chk("rst_async_cnt", 32'(match_cnt), 0);
    tick();
    rst = 1'b0;
    j = 1'b0; in_valid = 1'b1; tick(); clr_in();
    chk("post_rst_w", 32'(w), 0);
    chk("post_rst_armed", 32'(armed), 0);
    // reset configuration: pattern 0, length MAX_LEN
    arm = 1'b1; tick(); clr_in();
    send(32'b0, 8, wv);
    chk("reset_cfg_match", wv, 32'b00000001);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      clr_in();
      disarm      = ($urandom_range(0, 39) == 0);
      arm         = ($urandom_range(0, 9) == 0);
      cfg_we      = ($urandom_range(0, 24) == 0);
      cfg_len     = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 9)) : LW'($urandom_range(1, 3));
      cfg_pattern = ML'($urandom);
      cfg_overlap = 1'($urandom);
      in_valid    = ($urandom_range(0, 9) < 7);
      j           = 1'($urandom);
      rst         = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; clr_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
